cfa_grad_gen: RTL and testbench
===============================

CFA_GRAD_GEN -- requirements
Module: cfa_grad_gen

Interface
- REQ-001: Parameter PIX_W, default 12, raw Bayer pixel width in bits.
- REQ-002: Parameter GRAD_W, default 8, gradient output width; values saturate to 2^GRAD_W-1.
- REQ-003: Parameter IMG_W, default 64, pixels per line; legal range 3..1024.
- REQ-004: Parameter IMG_H, default 48, lines per frame; legal range 3..4095.
- REQ-005: Port clk, input, 1 bit, single clock; all logic rising-edge.
- REQ-006: Port rst, input, 1 bit, asynchronous, active-low reset.
- REQ-007: Port pix_in, input, PIX_W bits, raster-order Bayer pixel.
- REQ-008: Port pix_valid, input, 1 bit, pix_in valid this cycle; no backpressure.
- REQ-009: Port sof, input, 1 bit, start of frame; qualified by pix_valid; marks pixel (0,0).
- REQ-010: Port h, output, GRAD_W bits, horizontal gradient of the window centre.
- REQ-011: Port v, output, GRAD_W bits, vertical gradient of the window centre.
- REQ-012: Port Gh, output, PIX_W+1 bits, horizontal green sum.
- REQ-013: Port Gv, output, PIX_W+1 bits, vertical green sum.
- REQ-014: Port ready, output, 1 bit, h/v/Gh/Gv valid this cycle; one-cycle pulse per interior pixel.
- REQ-015: Port frame_err, output, 1 bit, one-cycle pulse on sof received in ACTIVE state.

Function
- REQ-016: For centre pixel P(x,y), h SHALL be min(|P(x-1,y)-P(x+1,y)|, 2^GRAD_W-1).
- REQ-017: v SHALL be min(|P(x,y-1)-P(x,y+1)|, 2^GRAD_W-1).
- REQ-018: Gh SHALL be P(x-1,y)+P(x+1,y), Gv SHALL be P(x,y-1)+P(x,y+1), full PIX_W+1 width, unscaled, no overflow.
- REQ-019: Outputs SHALL be produced only for interior pixels 1<=x<=IMG_W-2, 1<=y<=IMG_H-2, in raster order: exactly (IMG_W-2)*(IMG_H-2) ready pulses per frame.
- REQ-020: ready SHALL assert exactly 2 clk cycles after the pix_valid cycle delivering P(x+1,y+1); the pipeline advances every clock, independent of pix_valid gaps.
- REQ-021: Outputs SHALL hold their last values while ready is low.
- REQ-022: FSM states IDLE, ACTIVE, DONE; IDLE->ACTIVE on pix_valid&sof; ACTIVE->DONE on acceptance of pixel (IMG_W-1,IMG_H-1); DONE->ACTIVE on pix_valid&sof.
- REQ-023: In IDLE and DONE, pix_valid without sof SHALL be ignored (no buffer write, no output).
- REQ-024: sof in ACTIVE SHALL pulse frame_err, reset column/row counters, treat that pixel as (0,0), and suppress outputs whose window spans the abandoned frame; outputs already in the 2-stage pipeline still emit.
- REQ-025: Column counter SHALL wrap IMG_W-1->0 with row increment; the row counter does not wrap within a frame.
- REQ-026: Two line buffers of IMG_W x PIX_W SHALL hold rows y-1 and y; read-before-write at the same column address in one cycle.

Reset
- REQ-027: On rst low: FSM=IDLE, counters=0, h=v=Gh=Gv=0, ready=0, frame_err=0, window registers=0; line-buffer contents undefined and never emitted.
- REQ-028: Reset assertion mid-frame SHALL abort the frame; the next output requires a fresh sof.

Structure
- REQ-029: Shared package holds the FSM state encoding and the saturating absolute-difference width constants.
- REQ-030: One sub-module cfa_line_buf (single-port synchronous RAM, depth IMG_W, width PIX_W), instantiated twice.

Verification
- REQ-031: 8x6 frame, all pixels 100 -> 24 ready pulses, h=v=0, Gh=Gv=200.
- REQ-032: 8x6 horizontal ramp P=4x -> h=8, v=0, Gh=8x, Gv=8x at every output.
- REQ-033: 8x6, row 0 = 0, rows 1..5 = 4095 -> at y=1: v=255 (saturated), Gv=4095, h=0, Gh=8190.
- REQ-034: pix_valid toggling every other cycle on test REQ-031 -> identical values and count; each ready is 2 cycles after its completing pixel.
- REQ-035: sof reasserted at pixel 20 of a frame -> frame_err pulses once; new full frame then yields 24 correct outputs.
- REQ-036: rst low for 1 cycle mid-frame -> all outputs 0 immediately; no ready until a new sof frame fills 2 lines plus 2 pixels.

Source files
------------

// File: rtl/cfa_grad_gen_pkg.sv
// Shared types and constants for the CFA gradient generator.
// Holds the frame FSM encoding and the saturating |a-b| width helpers.
package cfa_grad_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // One extra bit so a pixel difference keeps its sign.
    localparam int DIFF_GUARD = 1;

    function automatic int sat_max(input int gw);
        return (1 << gw) - 1;
    endfunction

endpackage

// File: rtl/cfa_line_buf.sv
// Single-port synchronous line RAM, read-before-write at one address.
// Ports: clk, en (access), we (write), addr, wdata, rdata (registered old word).
module cfa_line_buf
    import cfa_grad_gen_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) begin
                mem[addr] <= wdata;
            end
        end
    end

endmodule

// File: rtl/cfa_grad_gen.sv
// 3x3 Bayer window gradients: h/v saturated |diff|, Gh/Gv neighbour sums.
// Ports: clk, rst (async low), pix_in/pix_valid/sof in; h, v, Gh, Gv, ready, frame_err out.
module cfa_grad_gen
    import cfa_grad_gen_pkg::*;
#(
    parameter int PIX_W  = 12,
    parameter int GRAD_W = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PIX_W-1:0]  pix_in,
    input  logic              pix_valid,
    input  logic              sof,
    output logic [GRAD_W-1:0] h,
    output logic [GRAD_W-1:0] v,
    output logic [PIX_W:0]    Gh,
    output logic [PIX_W:0]    Gv,
    output logic              ready,
    output logic              frame_err
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int DW = PIX_W + DIFF_GUARD;
    localparam logic [PIX_W-1:0] SAT = PIX_W'(sat_max(GRAD_W));

    state_t state, state_nx;
    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    logic restart, acc, last_pix, emit, sel;

    // Stage 1: RAM outputs plus the pixel that triggered the read
    logic             v1, e1, sel1;
    logic [PIX_W-1:0] pix1, q0, q1, top, mid;

    // Window: mid row cols c-1/c-2, top/bottom at col c-1
    logic [PIX_W-1:0] mid_a, mid_b, top_a, bot_a;
    logic [DW-1:0]    hd_s, vd_s;
    logic [PIX_W-1:0] hd, vd;

    always_comb begin
        restart  = pix_valid & sof;
        acc      = pix_valid & (sof | (state == ST_ACTIVE));
        cur_col  = restart ? '0 : col;
        cur_row  = restart ? '0 : row;
        last_pix = (cur_col == CW'(IMG_W - 1)) &&
                   (cur_row == RW'(IMG_H - 1));
        // A pixel at (c,r) completes the window centred on (c-1,r-1)
        emit     = (cur_col >= CW'(2)) && (cur_row >= RW'(2));
        sel      = cur_row[0];
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (restart) state_nx = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (acc && last_pix) state_nx = ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            col       <= '0;
            row       <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            frame_err <= restart && (state == ST_ACTIVE);
            if (acc) begin
                if (last_pix) begin
                    col <= '0;
                    row <= '0;
                end else if (cur_col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= cur_row + RW'(1);
                end else begin
                    col <= cur_col + CW'(1);
                    row <= cur_row;
                end
            end
        end
    end

    // Buffers alternate by row parity: the one matching the current row
    // holds row r-2 and is overwritten in place; the other holds row r-1.
    cfa_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk   (clk),
        .en    (acc),
        .we    (acc & ~sel),
        .addr  (cur_col),
        .wdata (pix_in),
        .rdata (q0)
    );

    cfa_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk   (clk),
        .en    (acc),
        .we    (acc & sel),
        .addr  (cur_col),
        .wdata (pix_in),
        .rdata (q1)
    );

    always_comb begin
        top  = sel1 ? q1 : q0;
        mid  = sel1 ? q0 : q1;
        hd_s = {1'b0, mid_b} - {1'b0, mid};
        vd_s = {1'b0, top_a} - {1'b0, bot_a};
        hd   = hd_s[DW-1] ? PIX_W'(-hd_s) : hd_s[PIX_W-1:0];
        vd   = vd_s[DW-1] ? PIX_W'(-vd_s) : vd_s[PIX_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1    <= 1'b0;
            e1    <= 1'b0;
            sel1  <= 1'b0;
            pix1  <= '0;
            mid_a <= '0;
            mid_b <= '0;
            top_a <= '0;
            bot_a <= '0;
            h     <= '0;
            v     <= '0;
            Gh    <= '0;
            Gv    <= '0;
            ready <= 1'b0;
        end else begin
            v1    <= acc;
            e1    <= acc & emit;
            sel1  <= sel;
            pix1  <= pix_in;
            ready <= v1 & e1;
            if (v1) begin
                mid_a <= mid;
                mid_b <= mid_a;
                top_a <= top;
                bot_a <= pix1;
            end
            if (v1 && e1) begin
                h  <= (hd > SAT) ? SAT[GRAD_W-1:0] : hd[GRAD_W-1:0];
                v  <= (vd > SAT) ? SAT[GRAD_W-1:0] : vd[GRAD_W-1:0];
                Gh <= {1'b0, mid_b} + {1'b0, mid};
                Gv <= {1'b0, top_a} + {1'b0, bot_a};
            end
        end
    end

endmodule

// File: tb/tb_cfa_grad_gen.sv
// Scoreboard bench for cfa_grad_gen on an 8x6 frame.
// Driver pushes expected windows; a negedge monitor pops and compares.
module tb_cfa_grad_gen;

    localparam int IW = 8;
    localparam int IH = 6;

    logic        clk = 0;
    logic        rst;
    logic [11:0] pix_in;
    logic        pix_valid;
    logic        sof;
    logic [7:0]  h, v;
    logic [12:0] Gh, Gv;
    logic        ready;
    logic        frame_err;

    typedef struct {
        int x, y, h, v, gh, gv, cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ferr_cnt = 0;
    int   exp_ferr = 0;
    int   lh = 0, lv = 0, lgh = 0, lgv = 0;

    cfa_grad_gen #(
        .PIX_W(12), .GRAD_W(8), .IMG_W(IW), .IMG_H(IH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .sof       (sof),
        .h         (h),
        .v         (v),
        .Gh        (Gh),
        .Gv        (Gv),
        .ready     (ready),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic int sat(input int a);
        return (a > 255) ? 255 : a;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            checks++;
            if (h !== 0 || v !== 0 || Gh !== 0 || Gv !== 0 ||
                ready !== 0 || frame_err !== 0) begin
                errors++;
                $display("FAIL reset_state: h=%0d v=%0d Gh=%0d Gv=%0d rdy=%b fe=%b, need all 0",
                         h, v, Gh, Gv, ready, frame_err);
            end
            lh = 0; lv = 0; lgh = 0; lgv = 0;
        end else if (ready === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready: cyc=%0d h=%0d v=%0d, need no output",
                         cyc, h, v);
            end else begin
                e = sbq.pop_front();
                if (int'(h) != e.h || int'(v) != e.v || int'(Gh) != e.gh ||
                    int'(Gv) != e.gv || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL window(%0d,%0d): got h=%0d v=%0d Gh=%0d Gv=%0d cyc=%0d, need h=%0d v=%0d Gh=%0d Gv=%0d cyc=%0d",
                             e.x, e.y, h, v, Gh, Gv, cyc,
                             e.h, e.v, e.gh, e.gv, e.cyc);
                end
            end
            lh = int'(h); lv = int'(v); lgh = int'(Gh); lgv = int'(Gv);
        end else begin
            checks++;
            if (int'(h) != lh || int'(v) != lv ||
                int'(Gh) != lgh || int'(Gv) != lgv) begin
                errors++;
                $display("FAIL hold: cyc=%0d got h=%0d v=%0d Gh=%0d Gv=%0d, need %0d %0d %0d %0d",
                         cyc, h, v, Gh, Gv, lh, lv, lgh, lgv);
            end
        end
        if (frame_err === 1'b1) ferr_cnt++;
    end

    // mode: 0 flat 100, 1 ramp 4x, 2 row0=0 else 4095, 3 random
    // gap: 0 none, 1 one idle cycle per pixel, 2 random 0..3 idles
    task automatic send_frame(input int mode, input int npix, input int gap);
        int img [IH][IW];
        exp_t e;
        for (int i = 0; i < npix; i++) begin
            int x, y, p, ng;
            x = i % IW;
            y = i / IW;
            case (mode)
                0: p = 100;
                1: p = 4 * x;
                2: p = (y == 0) ? 0 : 4095;
                default: p = int'($urandom_range(0, 4095));
            endcase
            img[y][x] = p;
            @(posedge clk); #1;
            pix_valid = 1'b1;
            pix_in    = 12'(p);
            sof       = (i == 0);
            if (x >= 2 && y >= 2) begin
                e.x   = x - 1;
                e.y   = y - 1;
                e.h   = sat(absd(img[y-1][x-2], img[y-1][x]));
                e.v   = sat(absd(img[y-2][x-1], img[y][x-1]));
                e.gh  = img[y-1][x-2] + img[y-1][x];
                e.gv  = img[y-2][x-1] + img[y][x-1];
                e.cyc = cyc + 2;
                sbq.push_back(e);
            end
            ng = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 3)) : 0;
            for (int g = 0; g < ng; g++) begin
                @(posedge clk); #1;
                pix_valid = 1'b0;
                sof       = 1'b0;
                pix_in    = 12'($urandom);
            end
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic send_junk(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            pix_valid = 1'b1;
            sof       = 1'b0;
            pix_in    = 12'($urandom);
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        pix_valid = 1'b0;
        sof       = 1'b0;
        pix_in    = '0;
        idle(3);
        rst = 1'b1;
        idle(2);

        send_frame(0, IW * IH, 0);
        idle(4);
        send_junk(6);
        send_frame(1, IW * IH, 0);
        send_frame(2, IW * IH, 0);
        send_frame(0, IW * IH, 1);
        send_frame(3, IW * IH, 2);
        send_frame(3, IW * IH, 0);
        idle(4);

        // sof lands while the frame is still active
        send_frame(3, 20, 2);
        exp_ferr++;
        send_frame(3, IW * IH, 0);
        idle(5);

        // reset in the middle of a frame
        send_frame(3, 20, 0);
        idle(4);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        send_junk(10);
        send_frame(3, IW * IH, 1);
        idle(6);

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL missing_outputs: %0d pending, need 0", sbq.size());
        end
        checks++;
        if (ferr_cnt != exp_ferr) begin
            errors++;
            $display("FAIL frame_err_count: got %0d, need %0d", ferr_cnt, exp_ferr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
